// File: rtl/ace_pkg.sv
// ace_pkg -- shared ACE definitions for the CCU slave-port decode.
//
// Holds the raw AMBA ACE sideband types (snoop, domain, barrier), the
// extended transaction class enum ace_trs_ext_t, and the pure decode
// functions that turn AR/AW sideband fields into a class.
package ace_pkg;

  typedef logic [3:0] arsnoop_t;
  typedef logic [2:0] awsnoop_t;
  typedef logic [1:0] domain_t;
  typedef logic [1:0] bar_t;

  typedef enum logic [4:0] {
    TRS_READ_NO_SNOOP         = 5'd0,
    TRS_READ_ONCE             = 5'd1,
    TRS_READ_SHARED           = 5'd2,
    TRS_READ_CLEAN            = 5'd3,
    TRS_READ_NOT_SHARED_DIRTY = 5'd4,
    TRS_READ_UNIQUE           = 5'd5,
    TRS_CLEAN_UNIQUE          = 5'd6,
    TRS_MAKE_UNIQUE           = 5'd7,
    TRS_CLEAN_SHARED          = 5'd8,
    TRS_CLEAN_INVALID         = 5'd9,
    TRS_MAKE_INVALID          = 5'd10,
    TRS_DVM_COMPLETE          = 5'd11,
    TRS_DVM_MESSAGE           = 5'd12,
    TRS_WRITE_NO_SNOOP        = 5'd13,
    TRS_WRITE_UNIQUE          = 5'd14,
    TRS_WRITE_LINE_UNIQUE     = 5'd15,
    TRS_WRITE_CLEAN           = 5'd16,
    TRS_WRITE_BACK            = 5'd17,
    TRS_EVICT                 = 5'd18,
    TRS_WRITE_EVICT           = 5'd19,
    TRS_BARRIER               = 5'd20,
    TRS_ILLEGAL               = 5'd21
  } ace_trs_ext_t;

  localparam int unsigned NumTrsTypes = 22;

  // Non-shareable (00) and system (11) domains never need snooping.
  function automatic logic domain_no_snoop(domain_t domain);
    return (domain == 2'b00) || (domain == 2'b11);
  endfunction

  // Barrier bit takes precedence over whatever the snoop field says.
  function automatic ace_trs_ext_t decode_ar(arsnoop_t snoop, domain_t domain, bar_t bar);
    ace_trs_ext_t t;
    if (bar[0]) begin
      t = TRS_BARRIER;
    end else begin
      unique case (snoop)
        4'b0000: t = domain_no_snoop(domain) ? TRS_READ_NO_SNOOP : TRS_READ_ONCE;
        4'b0001: t = TRS_READ_SHARED;
        4'b0010: t = TRS_READ_CLEAN;
        4'b0011: t = TRS_READ_NOT_SHARED_DIRTY;
        4'b0111: t = TRS_READ_UNIQUE;
        4'b1011: t = TRS_CLEAN_UNIQUE;
        4'b1100: t = TRS_MAKE_UNIQUE;
        4'b1000: t = TRS_CLEAN_SHARED;
        4'b1001: t = TRS_CLEAN_INVALID;
        4'b1101: t = TRS_MAKE_INVALID;
        4'b1110: t = TRS_DVM_COMPLETE;
        4'b1111: t = TRS_DVM_MESSAGE;
        default: t = TRS_ILLEGAL;
      endcase
    end
    return t;
  endfunction

  function automatic ace_trs_ext_t decode_aw(awsnoop_t snoop, domain_t domain, bar_t bar);
    ace_trs_ext_t t;
    if (bar[0]) begin
      t = TRS_BARRIER;
    end else begin
      unique case (snoop)
        3'b000:  t = domain_no_snoop(domain) ? TRS_WRITE_NO_SNOOP : TRS_WRITE_UNIQUE;
        3'b001:  t = TRS_WRITE_LINE_UNIQUE;
        3'b010:  t = TRS_WRITE_CLEAN;
        3'b011:  t = TRS_WRITE_BACK;
        3'b100:  t = TRS_EVICT;
        3'b101:  t = TRS_WRITE_EVICT;
        default: t = TRS_ILLEGAL;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/ace_trs_fifo.sv
// ace_trs_fifo -- synchronous-reset FIFO carrying classified requests.
//
// Parameters: Depth (entries, >=1), T (entry type).
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, data_i     write request (ignored while full, even with a pop)
//   full_o             count == Depth
//   pop_i              read request (ignored while empty)
//   valid_o, data_o    head entry; data_o holds its last value when empty
//
// The head is kept in a dedicated register so the output is glitch-free,
// resets to zero and keeps its previous contents once the FIFO drains.
module ace_trs_fifo import ace_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output logic valid_o,
  output T     data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  T                head_q, head_d;
  logic            push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = head_q;

  always_comb begin
    push_en = push_i & ~full_o;
    pop_en  = pop_i & valid_o;
    wptr_d  = push_en ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_en ? ptr_inc(rptr_q) : rptr_q;
    cnt_d   = cnt_q;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    // If nothing older survives this cycle's pop, the pushed entry becomes
    // the head directly; otherwise the head is the stored slot at rptr_d.
    head_d = head_q;
    if (push_en && (cnt_q == CntW'(pop_en))) begin
      head_d = data_i;
    end else if (cnt_d != '0) begin
      head_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ace_trs_classifier.sv
// ace_trs_classifier -- ACE AR/AW transaction classifier for the CCU slave port.
//
// Decodes snoop/domain/barrier sideband of both address channels into the
// extended ACE class set, merges the channels with a round-robin arbiter and
// presents one buffered valid/ready classified-request stream.
//
// Optional feature macro: ACE_TRS_STATS_EN adds per-class saturating counters
// (clr_cnt_i, cnt_o). Without it those ports and counters do not exist.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ar_valid_i/ar_ready_o, ar_addr_i, ar_id_i, ar_snoop_i, ar_domain_i, ar_bar_i
//   aw_valid_i/aw_ready_o, aw_addr_i, aw_id_i, aw_snoop_i, aw_domain_i, aw_bar_i
//   trs_valid_o/trs_ready_i           classified-request handshake
//   trs_type_o, trs_addr_o, trs_id_o  class, address, ID of head request
//   trs_write_o, trs_illegal_o        came from AW; reserved encoding seen
//   clr_cnt_i, cnt_o                  (ACE_TRS_STATS_EN only) counter clear / values
module ace_trs_classifier import ace_pkg::*; #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  arsnoop_t             ar_snoop_i,
  input  domain_t              ar_domain_i,
  input  bar_t                 ar_bar_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  awsnoop_t             aw_snoop_i,
  input  domain_t              aw_domain_i,
  input  bar_t                 aw_bar_i,
`ifdef ACE_TRS_STATS_EN
  input  logic                          clr_cnt_i,
  output logic [NumTrsTypes*CntWidth-1:0] cnt_o,
`endif
  output logic                 trs_valid_o,
  input  logic                 trs_ready_i,
  output logic [4:0]           trs_type_o,
  output logic [AddrWidth-1:0] trs_addr_o,
  output logic [IdWidth-1:0]   trs_id_o,
  output logic                 trs_write_o,
  output logic                 trs_illegal_o
);

  typedef struct packed {
    ace_trs_ext_t         typ;
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   id;
    logic                 write;
    logic                 illegal;
  } entry_t;

  ace_trs_ext_t ar_type, aw_type;
  entry_t       ar_entry, aw_entry, push_entry, head;
  logic         grant_ar, grant_aw;
  logic         full, push, pop;
  // 0: AR wins a tie, 1: AW wins a tie.
  logic         prio_aw_q, prio_aw_d;

  always_comb begin
    ar_type  = decode_ar(ar_snoop_i, ar_domain_i, ar_bar_i);
    aw_type  = decode_aw(aw_snoop_i, aw_domain_i, aw_bar_i);
    ar_entry = '{typ: ar_type, addr: ar_addr_i, id: ar_id_i, write: 1'b0,
                 illegal: (ar_type == TRS_ILLEGAL)};
    aw_entry = '{typ: aw_type, addr: aw_addr_i, id: aw_id_i, write: 1'b1,
                 illegal: (aw_type == TRS_ILLEGAL)};
  end

  // Grant is a function of valids and the tie pointer only; readiness then
  // adds FIFO space. Reset gates ready so no handshake completes in that cycle.
  always_comb begin
    grant_ar   = ar_valid_i & (~aw_valid_i | ~prio_aw_q);
    grant_aw   = aw_valid_i & (~ar_valid_i |  prio_aw_q);
    ar_ready_o = grant_ar & ~full & ~rst_i;
    aw_ready_o = grant_aw & ~full & ~rst_i;
    push       = ar_ready_o | aw_ready_o;
    push_entry = grant_aw ? aw_entry : ar_entry;
    // The pointer only flips on a contested grant that was actually taken.
    prio_aw_d  = (ar_valid_i & aw_valid_i & push) ? ~prio_aw_q : prio_aw_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_aw_q <= 1'b0;
    end else begin
      prio_aw_q <= prio_aw_d;
    end
  end

  assign pop = trs_valid_o & trs_ready_i;

  ace_trs_fifo #(
    .Depth (Depth),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .full_o  (full),
    .pop_i   (pop),
    .valid_o (trs_valid_o),
    .data_o  (head)
  );

  assign trs_type_o    = head.typ;
  assign trs_addr_o    = head.addr;
  assign trs_id_o      = head.id;
  assign trs_write_o   = head.write;
  assign trs_illegal_o = head.illegal;

`ifdef ACE_TRS_STATS_EN
  logic [CntWidth-1:0] cnt_q [NumTrsTypes];
  logic [CntWidth-1:0] cnt_d [NumTrsTypes];

  // Saturating increment of the accepted class; clear overrides increment.
  always_comb begin
    for (int i = 0; i < NumTrsTypes; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt_i) begin
        cnt_d[i] = '0;
      end else if (push && (push_entry.typ == ace_trs_ext_t'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumTrsTypes; i++) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NumTrsTypes; g++) begin : g_cnt_out
    assign cnt_o[g*CntWidth +: CntWidth] = cnt_q[g];
  end
`endif

endmodule

// File: doc/ace_trs_classifier.md
# ace_trs_classifier

Parametrised successor to the ACE transaction-type decode used by the CCU. It accepts requests from an ACE AR and an AW address channel and decodes ARSNOOP/AWSNOOP, domain and barrier into the full ACE transaction set, not only the eight basic classes. A round-robin arbiter merges the two channels into one buffered, valid/ready classified-request stream. It sits at the CCU slave port, ahead of snoop generation.

## Interface
- AddrWidth, 64: address width.
- IdWidth, 4: AXI ID width.
- Depth, 4: output FIFO entries, ≥1.
- CntWidth, 16: per-class statistics counter width.

- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- ar_valid_i / ar_ready_o  in/out  1  AR request handshake.
- ar_addr_i  in  AddrWidth;  ar_id_i  in  IdWidth.
- ar_snoop_i  in  4 (arsnoop_t);  ar_domain_i  in  2 (domain_t);  ar_bar_i  in  2 (bar_t).
- aw_valid_i / aw_ready_o  in/out  1  AW request handshake.
- aw_addr_i, aw_id_i, aw_snoop_i (3, awsnoop_t), aw_domain_i, aw_bar_i: as AR.
- trs_valid_o / trs_ready_i  out/in  1  classified-request handshake.
- trs_type_o  out  5  ace_trs_ext_t class.
- trs_addr_o, trs_id_o  out  AddrWidth, IdWidth.
- trs_write_o  out  1  1 = came from AW.
- trs_illegal_o  out  1  reserved encoding.
- Under ACE_TRS_STATS_EN only: clr_cnt_i  in  1;  cnt_o  out  NumTrsTypes×CntWidth.

## Operation
- Decode (combinational, per channel):
  - Barrier: bar[0]=1 → BARRIER, regardless of snoop field.
  - AR, ARSNOOP 0000: domain 00/11 → READ_NO_SNOOP, otherwise READ_ONCE.
  - AR, other ARSNOOP: 0001 READ_SHARED, 0010 READ_CLEAN, 0011 READ_NOT_SHARED_DIRTY, 0111 READ_UNIQUE, 1011 CLEAN_UNIQUE, 1100 MAKE_UNIQUE, 1000 CLEAN_SHARED, 1001 CLEAN_INVALID, 1101 MAKE_INVALID, 1110 DVM_COMPLETE, 1111 DVM_MESSAGE.
  - AW, AWSNOOP 000: domain 00/11 → WRITE_NO_SNOOP, otherwise WRITE_UNIQUE.
  - AW, other AWSNOOP: 001 WRITE_LINE_UNIQUE, 010 WRITE_CLEAN, 011 WRITE_BACK, 100 EVICT, 101 WRITE_EVICT.
  - Any other encoding → type ILLEGAL, trs_illegal_o=1. The request is still enqueued, never dropped.
- Arbiter:
  - One request accepted per cycle, only when the FIFO is not full.
  - ar_ready_o = !full & (grant AR); aw_ready_o likewise.
  - Both valid: the priority pointer picks the winner. After each grant, the pointer moves to the other channel.
  - Only one valid: that channel is granted and the pointer is unchanged.
  - Ready is never asserted to a channel that is not granted. Ready does not depend on trs_ready_i.
- FIFO:
  - Depth entries of {type, addr, id, write, illegal}.
  - Read/write pointers wrap from Depth-1 to 0.
  - Pop when trs_valid_o & trs_ready_i.
  - Push on a full FIFO is never allowed, even with a simultaneous pop. Full depends only on the count.
- Reset (rst_i=1 at an edge):
  - FIFO emptied; pointer favours AR.
  - Outputs: trs_valid_o=0, ar_ready_o=0, aw_ready_o=0, trs_type_o=0, trs_addr_o=0, trs_id_o=0, trs_write_o=0, trs_illegal_o=0, cnt_o=0.
  - Reset mid-operation discards queued entries. Any handshake completing in the reset cycle is ignored.

## Timing
- Latency: a request accepted at edge N drives trs_valid_o=1 after edge N. There is no fall-through.
- Throughput: 1 request/cycle, sustained while trs_ready_i=1 and Depth≥2. Depth=1 gives at most 1 request per 2 cycles.
- Output fields are stable while trs_valid_o=1 and trs_ready_i=0.
- Empty: trs_valid_o=0 and output fields hold their last value.

## Configuration
- ACE_TRS_STATS_EN defined:
  - One CntWidth counter per ace_trs_ext_t value. It increments on each accepted request of that class.
  - Counters saturate at all-ones.
  - clr_cnt_i=1 zeroes all counters at the next edge. Clear wins over a same-cycle increment.
- Undefined: the counters, clr_cnt_i and cnt_o are absent. Behaviour is otherwise identical.

## Structure
- Shared package ace_pkg gains:
  - ace_trs_ext_t: 5-bit enum holding the classes above plus BARRIER and ILLEGAL.
  - NumTrsTypes localparam.
  - Pure functions decode_ar() and decode_aw().
- Existing arsnoop_t, awsnoop_t, domain_t and bar_t are reused.
- One sub-module, ace_trs_fifo: synchronous-reset FIFO with Depth and a type parameter.

## Test plan
- AR only, ARSNOOP=0111, domain=10, addr=0x1000, trs_ready_i=1 → one cycle later: READ_UNIQUE, addr 0x1000, write=0, illegal=0.
- AR and AW valid every cycle from reset, ready=1 → grants alternate AR, AW, AR, AW. Output order matches.
- AW with AWSNOOP=110 → type ILLEGAL, illegal=1, enqueued. AR with bar=01 and ARSNOOP=0010 → BARRIER.
- Depth=4, trs_ready_i=0, AR streaming → 4 accepts, then ar_ready_o=0. One pop frees one slot on the next cycle. Order is preserved across pointer wrap.
- rst_i pulsed with 3 entries queued → trs_valid_o=0 the next cycle. Next request appears one cycle after acceptance.
- ACE_TRS_STATS_EN, CntWidth=2: 5 WRITE_BACK requests → count saturates at 3. clr_cnt_i together with an increment → 0.
